// File: rtl/fp_op_master_if.sv
// Command/result handshakes and the FPU strobe/ack bus used by fp_op_master.
// Every valid/ready pair transfers on a rising edge where both are high; once valid rises it holds with stable data until that edge.
interface fp_op_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    logic [31:0] fpu_input_a;
    logic [31:0] fpu_input_b;
    logic        fpu_input_a_stb;
    logic        fpu_input_b_stb;
    logic        fpu_input_a_ack;
    logic        fpu_input_b_ack;
    logic [31:0] fpu_output_z;
    logic        fpu_output_z_stb;
    logic        fpu_output_z_ack;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, res_ready,
        input  fpu_input_a_ack, fpu_input_b_ack, fpu_output_z, fpu_output_z_stb,
        output cmd_ready, res_valid, res_data, res_timeout,
        output fpu_input_a, fpu_input_b, fpu_input_a_stb, fpu_input_b_stb, fpu_output_z_ack
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, res_ready,
        output fpu_input_a_ack, fpu_input_b_ack, fpu_output_z, fpu_output_z_stb,
        input  cmd_ready, res_valid, res_data, res_timeout,
        input  fpu_input_a, fpu_input_b, fpu_input_a_stb, fpu_input_b_stb, fpu_output_z_ack
    );
endinterface

// File: rtl/fp_op_master.sv
// Single-outstanding FPU sequencer: takes a command, drives the FPU strobe/ack
// handshakes with a per-phase timeout, and holds the result until consumed.
module fp_op_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    fp_op_master_if.master bus,
    output logic          busy,
    output logic [15:0]   op_count,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_DELIVER} state_e;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        stb_q, stb_d;
    logic        z_ack_q, z_ack_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_timeout_q, res_timeout_d;
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] timer_q, timer_d;
    logic        unused_b_ack;

    // The FPU's b-side ack carries no information beyond a_ack.
    assign unused_b_ack = bus.fpu_input_b_ack;

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        stb_d         = stb_q;
        z_ack_d       = z_ack_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        op_count_d    = op_count_q;
        timer_d       = timer_q;
        if (state_q == S_ISSUE || state_q == S_COLLECT) begin
            timer_d = timer_q + 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    stb_d   = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The handshake is tested first so it wins over a same-edge timeout.
                if (stb_q && bus.fpu_input_a_ack) begin
                    stb_d   = 1'b0;
                    z_ack_d = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_COLLECT;
                end else if (timer_q == TIMER_LAST) begin
                    stb_d         = 1'b0;
                    z_ack_d       = 1'b0;
                    res_data_d    = TIMEOUT_NAN;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = S_DELIVER;
                end
            end
            S_COLLECT: begin
                if (z_ack_q && bus.fpu_output_z_stb) begin
                    res_data_d    = bus.fpu_output_z;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    z_ack_d       = 1'b0;
                    op_count_d    = op_count_q + 16'd1;
                    state_d       = S_DELIVER;
                end else if (timer_q == TIMER_LAST) begin
                    stb_d         = 1'b0;
                    z_ack_d       = 1'b0;
                    res_data_d    = TIMEOUT_NAN;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            stb_q         <= 1'b0;
            z_ack_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= 32'd0;
            res_timeout_q <= 1'b0;
            op_count_q    <= 16'd0;
            timer_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            stb_q         <= stb_d;
            z_ack_q       <= z_ack_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            op_count_q    <= op_count_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.cmd_ready        = (state_q == S_IDLE);
    assign busy                 = (state_q != S_IDLE);
    assign bus.fpu_input_a      = a_q;
    assign bus.fpu_input_b      = b_q;
    assign bus.fpu_input_a_stb  = stb_q;
    assign bus.fpu_input_b_stb  = stb_q;
    assign bus.fpu_output_z_ack = z_ack_q;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_data         = res_data_q;
    assign bus.res_timeout      = res_timeout_q;
    assign op_count             = op_count_q;
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_fp_op_master.sv
// Bench for fp_op_master: table vectors, random operations against a
// phase-timing reference model, reset-in-flight and op_count wrap sequences.
module tb_fp_op_master;
    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] op_count;
    logic [1:0]  dbg_state;

    fp_op_master_if bus ();

    fp_op_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .op_count  (op_count),
        .dbg_state (dbg_state)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_cnt = 16'd0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int          ack_dly;
        int          z_dly;
        int          rdy_dly;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                          input int ack_dly, input int z_dly, input int rdy_dly,
                          input logic [31:0] exp_data, input logic exp_to);
        int          n;
        int          stb_cyc;
        int          ack_cyc;
        int          hold_bad;
        int          exp_issue;
        int          exp_collect;
        logic [31:0] mis_a;
        logic [31:0] mis_b;
        logic        stb_pair_bad;
        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        mis_a = a;
        mis_b = b;
        stb_pair_bad = 1'b0;
        stb_cyc = 0;
        n = 0;
        while (bus.fpu_input_a_stb && n < 4 * T) begin
            if (bus.fpu_input_a !== a) mis_a = bus.fpu_input_a;
            if (bus.fpu_input_b !== b) mis_b = bus.fpu_input_b;
            if (bus.fpu_input_b_stb !== bus.fpu_input_a_stb) stb_pair_bad = 1'b1;
            bus.fpu_input_a_ack = (n >= ack_dly);
            bus.fpu_input_b_ack = 1'($urandom);
            stb_cyc++;
            @(posedge clk); #1;
            n++;
        end
        bus.fpu_input_a_ack = 1'b0;
        bus.fpu_input_b_ack = 1'b0;
        exp_issue = (ack_dly >= T) ? T : ack_dly + 1;
        chk("issue_cycles", stb_cyc, exp_issue);
        ack_cyc = 0;
        n = 0;
        while (bus.fpu_output_z_ack && n < 4 * T) begin
            if (bus.fpu_input_a !== a) mis_a = bus.fpu_input_a;
            if (bus.fpu_input_b !== b) mis_b = bus.fpu_input_b;
            bus.fpu_output_z_stb = (n >= z_dly);
            bus.fpu_output_z     = (n >= z_dly) ? z : $urandom;
            ack_cyc++;
            @(posedge clk); #1;
            n++;
        end
        exp_collect = (ack_dly >= T) ? 0 : ((z_dly >= T) ? T : z_dly + 1);
        chk("collect_cycles", ack_cyc, exp_collect);
        if (!exp_to) model_cnt = model_cnt + 16'd1;
        exp_q.push_back(exp_data);
        chk("res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("res_data", bus.res_data, exp_q.pop_front());
        chk("res_timeout", {31'd0, bus.res_timeout}, {31'd0, exp_to});
        chk("strobes_off", {30'd0, bus.fpu_input_a_stb, bus.fpu_output_z_ack}, 32'd0);
        // A lingering z strobe and a second offered command must both be ignored here.
        bus.res_ready = 1'b0;
        bus.cmd_valid = (rdy_dly > 0);
        bus.cmd_a     = $urandom;
        hold_bad = 0;
        for (int k = 0; k < rdy_dly; k++) begin
            @(posedge clk); #1;
            bus.fpu_output_z_stb = 1'b0;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data ||
                bus.res_timeout !== exp_to || bus.cmd_ready !== 1'b0 ||
                bus.fpu_input_a !== a) hold_bad++;
        end
        chk("deliver_hold", hold_bad, 0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready        = 1'b0;
        bus.cmd_valid        = 1'b0;
        bus.fpu_output_z_stb = 1'b0;
        chk("opnd_a", mis_a, a);
        chk("opnd_b", mis_b, b);
        chk("stb_pair", {31'd0, stb_pair_bad}, 32'd0);
        chk("res_consumed", {29'd0, busy, bus.res_valid, bus.cmd_ready}, 32'd1);
        chk("op_count", {16'd0, op_count}, {16'd0, model_cnt});
    endtask

    initial begin
        vecs[0] = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,  0,  0,  0, 32'h4000_0000, 1'b0};
        vecs[1] = '{32'h4120_0000, 32'h4000_0000, 32'h4110_0000,  5,  7,  1, 32'h4110_0000, 1'b0};
        vecs[2] = '{32'hC000_0000, 32'h3F00_0000, 32'hC020_0000,  1,  2, 10, 32'hC020_0000, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_AAAA, 99,  0,  0, 32'h7FC0_0000, 1'b1};
        vecs[4] = '{32'h0000_0001, 32'h8000_0001, 32'hAAAA_5555,  0, 99,  2, 32'h7FC0_0000, 1'b1};
        vecs[5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 15, 15,  0, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h7F7F_FFFF, 32'h0080_0000, 32'hDEAD_BEEF, 16,  0,  1, 32'h7FC0_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_F00D,  3, 16,  0, 32'h7FC0_0000, 1'b1};

        rst                  = 1'b0;
        bus.cmd_valid        = 1'b0;
        bus.cmd_a            = 32'd0;
        bus.cmd_b            = 32'd0;
        bus.res_ready        = 1'b0;
        bus.fpu_input_a_ack  = 1'b0;
        bus.fpu_input_b_ack  = 1'b0;
        bus.fpu_output_z     = 32'd0;
        bus.fpu_output_z_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {27'd0, busy, bus.res_valid, bus.res_timeout,
                          bus.fpu_input_a_stb, bus.fpu_output_z_ack}, 32'd0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_opnd", bus.fpu_input_a | bus.fpu_input_b, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].ack_dly, vecs[i].z_dly,
                   vecs[i].rdy_dly, vecs[i].exp_data, vecs[i].exp_to);
        end

        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rb, rz, rexp;
            int          ad, zd, rd;
            logic        rto;
            ra = $urandom;
            rb = $urandom;
            rz = $urandom;
            ad = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 6);
            zd = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 6);
            rd = $urandom_range(0, 4);
            rto  = (ad >= T) || (zd >= T);
            rexp = rto ? 32'h7FC0_0000 : rz;
            run_op(ra, rb, rz, ad, zd, rd, rexp, rto);
        end

        // Reset while waiting for the FPU result: no result, counter cleared.
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 32'h4080_0000;
        bus.cmd_b     = 32'h4000_0000;
        @(posedge clk); #1;
        bus.cmd_valid       = 1'b0;
        bus.fpu_input_a_ack = 1'b1;
        @(posedge clk); #1;
        bus.fpu_input_a_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_collect", {31'd0, bus.fpu_output_z_ack}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_flags", {28'd0, busy, bus.fpu_input_a_stb,
                                bus.fpu_output_z_ack, bus.res_valid}, 32'd0);
        chk("async_rst_count", {16'd0, op_count}, 32'd0);
        model_cnt = 16'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_result", {31'd0, bus.res_valid}, 32'd0);
        run_op(vecs[0].a, vecs[0].b, vecs[0].z, 0, 0, 0, vecs[0].exp_data, 1'b0);

        // Wrap: preload the counter one short of all-ones.
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        model_cnt = 16'hFFFE;
        run_op(vecs[1].a, vecs[1].b, vecs[1].z, 1, 1, 0, vecs[1].z, 1'b0);
        chk("wrap_ffff", {16'd0, op_count}, 32'h0000_FFFF);
        run_op(vecs[2].a, vecs[2].b, vecs[2].z, 0, 2, 0, vecs[2].z, 1'b0);
        chk("wrap_zero", {16'd0, op_count}, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
